// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive frame sequencer. It drives the edge/bit counter,
//            deserialises data LSB-first, and checks parity and stop.
//            Optional UART_RX_ERR_CNT_EN adds a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            prescale,
    input  logic [3:0]            bit_cnt,
    input  logic [4:0]            edge_cnt,
    input  logic                  sampled_bit,
`ifdef UART_RX_ERR_CNT_EN
    input  logic                  err_cnt_clr,
    output logic [7:0]            err_cnt,
`endif
    output logic                  cnt_enable,
    output logic [5:0]            cnt_prescale,
    output logic                  sample_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] c_last_data_bit = 4'(DATA_WIDTH);

    state_t                r_state,        w_state_nxt;
    logic                  r_cnt_enable,   w_cnt_enable_nxt;
    logic                  r_sample_en,    w_sample_en_nxt;
    logic [5:0]            r_cnt_prescale, w_cnt_prescale_nxt;
    logic                  r_par_en,       w_par_en_nxt;
    logic                  r_par_typ,      w_par_typ_nxt;
    logic [DATA_WIDTH-1:0] r_shift,        w_shift_nxt;
    logic                  r_par_fail,     w_par_fail_nxt;
    logic [DATA_WIDTH-1:0] r_p_data,       w_p_data_nxt;
    logic                  r_data_valid,   w_data_valid_nxt;
    logic                  r_par_err,      w_par_err_nxt;
    logic                  r_stp_err,      w_stp_err_nxt;

    logic [5:0] w_edge_ext;
    logic [5:0] w_prescale_sel;
    logic       w_bit_end;
    logic       w_par_exp;

    assign w_edge_ext     = {1'b0, edge_cnt};
    assign w_prescale_sel = (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32)
                            ? prescale : 6'd8;

    // The counter shortens the start bit by one edge to absorb the detection cycle.
    assign w_bit_end = r_cnt_enable &
                       (((bit_cnt == 4'd0) & (w_edge_ext == r_cnt_prescale - 6'd2)) |
                        ((bit_cnt != 4'd0) & (w_edge_ext == r_cnt_prescale - 6'd1)));

    assign w_par_exp = (^r_shift) ^ r_par_typ;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt_enable   <= 1'b0;
            r_sample_en    <= 1'b0;
            r_cnt_prescale <= 6'd8;
            r_par_en       <= 1'b0;
            r_par_typ      <= 1'b0;
            r_shift        <= '0;
            r_par_fail     <= 1'b0;
            r_p_data       <= '0;
            r_data_valid   <= 1'b0;
            r_par_err      <= 1'b0;
            r_stp_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt_enable   <= w_cnt_enable_nxt;
            r_sample_en    <= w_sample_en_nxt;
            r_cnt_prescale <= w_cnt_prescale_nxt;
            r_par_en       <= w_par_en_nxt;
            r_par_typ      <= w_par_typ_nxt;
            r_shift        <= w_shift_nxt;
            r_par_fail     <= w_par_fail_nxt;
            r_p_data       <= w_p_data_nxt;
            r_data_valid   <= w_data_valid_nxt;
            r_par_err      <= w_par_err_nxt;
            r_stp_err      <= w_stp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_enable_nxt   = r_cnt_enable;
        w_sample_en_nxt    = r_sample_en;
        w_cnt_prescale_nxt = r_cnt_prescale;
        w_par_en_nxt       = r_par_en;
        w_par_typ_nxt      = r_par_typ;
        w_shift_nxt        = r_shift;
        w_par_fail_nxt     = r_par_fail;
        w_p_data_nxt       = r_p_data;
        w_data_valid_nxt   = 1'b0;
        w_par_err_nxt      = 1'b0;
        w_stp_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_enable_nxt = 1'b0;
                w_sample_en_nxt  = 1'b0;
                if (!rx_in) begin
                    w_state_nxt        = S_START;
                    w_cnt_enable_nxt   = 1'b1;
                    w_sample_en_nxt    = 1'b1;
                    w_cnt_prescale_nxt = w_prescale_sel;
                    w_par_en_nxt       = par_en;
                    w_par_typ_nxt      = par_typ;
                    w_par_fail_nxt     = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    if (sampled_bit) begin
                        w_state_nxt      = S_IDLE;
                        w_cnt_enable_nxt = 1'b0;
                        w_sample_en_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {sampled_bit, r_shift[DATA_WIDTH-1:1]};
                    if (bit_cnt == c_last_data_bit) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    if (sampled_bit != w_par_exp) begin
                        w_par_fail_nxt = 1'b1;
                        w_par_err_nxt  = 1'b1;
                    end
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_stp_err_nxt = ~sampled_bit;
                    if (sampled_bit && !r_par_fail) begin
                        w_p_data_nxt     = r_shift;
                        w_data_valid_nxt = 1'b1;
                    end
                    w_state_nxt      = S_IDLE;
                    w_cnt_enable_nxt = 1'b0;
                    w_sample_en_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_cnt_enable_nxt = 1'b0;
                w_sample_en_nxt  = 1'b0;
            end
        endcase
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Parity and stop strobes never coincide, so one increment per edge suffices.
    always_ff @(posedge clk) begin
        if (reset || err_cnt_clr) begin
            r_err_cnt <= 8'd0;
        end else if ((w_par_err_nxt || w_stp_err_nxt) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign cnt_enable   = r_cnt_enable;
    assign cnt_prescale = r_cnt_prescale;
    assign sample_en    = r_sample_en;
    assign p_data       = r_p_data;
    assign data_valid   = r_data_valid;
    assign par_err      = r_par_err;
    assign stp_err      = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Self-checking bench for uart_rx_ctrl with an edge/bit counter
//            model and a frame-level reference of the expected strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_in = 1'b1;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic [5:0]   prescale = 6'd8;
    logic [3:0]   bit_cnt = 4'd0;
    logic [4:0]   edge_cnt = 5'd0;
    logic         sampled_bit;
    logic         cnt_enable;
    logic [5:0]   cnt_prescale;
    logic         sample_en;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         par_err;
    logic         stp_err;
`ifdef UART_RX_ERR_CNT_EN
    logic         err_cnt_clr = 1'b0;
    logic [7:0]   err_cnt;
    int           exp_err_cnt = 0;
`endif

    logic [15:0]  line_bits = 16'hFFFF;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_pdata = '0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .prescale     (prescale),
        .bit_cnt      (bit_cnt),
        .edge_cnt     (edge_cnt),
        .sampled_bit  (sampled_bit),
`ifdef UART_RX_ERR_CNT_EN
        .err_cnt_clr  (err_cnt_clr),
        .err_cnt      (err_cnt),
`endif
        .cnt_enable   (cnt_enable),
        .cnt_prescale (cnt_prescale),
        .sample_en    (sample_en),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    // Edge/bit counter: start bit one edge short, cleared whenever disabled.
    always @(posedge clk) begin
        if (!cnt_enable) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (((bit_cnt == 4'd0) && ({1'b0, edge_cnt} == cnt_prescale - 6'd2)) ||
                     ((bit_cnt != 4'd0) && ({1'b0, edge_cnt} == cnt_prescale - 6'd1))) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    assign sampled_bit = line_bits[bit_cnt];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input logic [7:0] data, input logic pe, input logic pbit,
                            input logic stopb, input logic glitch, output int stop_idx);
        line_bits    = 16'hFFFF;
        line_bits[0] = glitch;
        for (int i = 0; i < W; i++) line_bits[i+1] = data[i];
        stop_idx = W + 1;
        if (pe) begin
            line_bits[W+1] = pbit;
            stop_idx = W + 2;
        end
        line_bits[stop_idx] = stopb;
    endtask

    // Sends one frame starting at a negedge and ends at the negedge where cnt_enable is seen low.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic pe,
                             input logic pt, input logic pbit, input logic stopb,
                             input logic [5:0] ps, input int gap, input logic glitch);
        int   s, p_eff, exp_end, k, dv_n, pe_n, se_n, limit;
        logic exp_perr, exp_serr, exp_dv, done;
        p_eff    = (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
        set_line(data, pe, pbit, stopb, glitch, s);
        exp_perr = !glitch && pe && (pbit != ((^data) ^ pt));
        exp_serr = !glitch && !stopb;
        exp_dv   = !glitch && !exp_perr && !exp_serr;
        exp_end  = glitch ? p_eff - 1 : (s + 1) * p_eff - 1;
        limit    = 12 * p_eff + 8;
        dv_n = 0; pe_n = 0; se_n = 0; done = 1'b0; k = 0;

        repeat (gap) @(negedge clk);
        prescale = ps; par_en = pe; par_typ = pt; rx_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rx_in    = ~glitch;
        prescale = 6'($urandom_range(0, 63));
        par_en   = 1'($urandom_range(0, 1));
        par_typ  = 1'($urandom_range(0, 1));
        check({tag, "_prescale_latch"}, 32'(cnt_prescale), 32'(p_eff));
        check({tag, "_sample_en"}, 32'(sample_en), 32'd1);
        for (k = 0; k < limit; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) rx_in = 1'b1;
            if (data_valid) dv_n++;
            if (par_err) pe_n++;
            if (stp_err) se_n++;
            if (!cnt_enable) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_end_cycle"}, done ? k : -1, exp_end);
        check({tag, "_data_valid"}, dv_n, exp_dv ? 1 : 0);
        check({tag, "_par_err"}, pe_n, exp_perr ? 1 : 0);
        check({tag, "_stp_err"}, se_n, exp_serr ? 1 : 0);
        if (exp_dv) exp_pdata = data;
        check({tag, "_p_data"}, 32'(p_data), 32'(exp_pdata));
        check({tag, "_prescale_hold"}, 32'(cnt_prescale), 32'(p_eff));
`ifdef UART_RX_ERR_CNT_EN
        if (err_cnt_clr) exp_err_cnt = 0;
        else begin
            exp_err_cnt = exp_err_cnt + (exp_perr ? 1 : 0) + (exp_serr ? 1 : 0);
            if (exp_err_cnt > 255) exp_err_cnt = 255;
        end
        check({tag, "_err_cnt"}, 32'(err_cnt), exp_err_cnt);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ps_tab [8];
        int         s;
        ps_tab = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd63, 6'd8, 6'd16};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
        check("rst_sample_en", 32'(sample_en), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_stp_err", 32'(stp_err), 32'd0);
        check("rst_p_data", 32'(p_data), 32'd0);
        check("rst_cnt_prescale", 32'(cnt_prescale), 32'd8);
`ifdef UART_RX_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 2, 1'b0);
        @(negedge clk);
        check("a5_idle_after", 32'(cnt_enable), 32'd0);

        run_frame("3c_parerr", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 6'd16, 1, 1'b0);
        run_frame("55_stperr", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8, 1, 1'b0);
        run_frame("0f_b2b", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 0, 1'b0);
        run_frame("glitch", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 1, 1'b1);

        // Reset in the middle of data bit 4.
        set_line(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, s);
        prescale = 6'd16; rx_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rx_in = 1'b1;
        for (int i = 0; i < 200 && bit_cnt != 4'd4; i++) @(negedge clk);
        check("midrst_reach_bit4", 32'(bit_cnt), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_cnt_enable", 32'(cnt_enable), 32'd0);
        check("midrst_sample_en", 32'(sample_en), 32'd0);
        check("midrst_strobes", 32'({data_valid, par_err, stp_err}), 32'd0);
        exp_pdata = '0;
`ifdef UART_RX_ERR_CNT_EN
        exp_err_cnt = 0;
`endif
        run_frame("81_after_rst", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 1, 1'b0);

        run_frame("7e_ps12", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 1, 1'b0);
        run_frame("both_err", 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 6'd8, 1, 1'b0);
        run_frame("odd_ok", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 6'd32, 1, 1'b0);

        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic       pe, pt, pb, sb;
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = ((^d) ^ pt) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rnd%0d", n), d, pe, pt, pb, sb,
                      ps_tab[$urandom_range(0, 7)], $urandom_range(0, 3), 1'b0);
        end

`ifdef UART_RX_ERR_CNT_EN
        err_cnt_clr = 1'b1;
        @(negedge clk);
        err_cnt_clr = 1'b0;
        exp_err_cnt = 0;
        check("errcnt_clear", 32'(err_cnt), 32'd0);
        for (int n = 0; n < 256; n++)
            run_frame("sat", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8, 0, 1'b0);
        check("errcnt_saturated", 32'(err_cnt), 32'd255);
        err_cnt_clr = 1'b1;
        run_frame("clr_wins", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8, 1, 1'b0);
        err_cnt_clr = 1'b0;
        @(negedge clk);
        check("errcnt_after_clr", 32'(err_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
